// File: rtl/axi_up_mem_slv_if.sv
// AXI4 bus bundle (AW, W, B, AR, R) linking the plugin copy master to the
// axi_up_mem_slv scratch memory responder.
interface axi_up_mem_slv_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 6,
  parameter int USER_WIDTH = 6
);
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awlock;
  logic [3:0]              awcache;
  logic [2:0]              awprot;
  logic [3:0]              awqos;
  logic [3:0]              awregion;
  logic [USER_WIDTH-1:0]   awuser;
  logic                    awvalid;
  logic                    awready;

  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic [USER_WIDTH-1:0]   wuser;
  logic                    wvalid;
  logic                    wready;

  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic [USER_WIDTH-1:0]   buser;
  logic                    bvalid;
  logic                    bready;

  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arlock;
  logic [3:0]              arcache;
  logic [2:0]              arprot;
  logic [3:0]              arqos;
  logic [3:0]              arregion;
  logic [USER_WIDTH-1:0]   aruser;
  logic                    arvalid;
  logic                    arready;

  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic [USER_WIDTH-1:0]   ruser;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awuser, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wuser, wvalid,
    input  wready,
    input  bid, bresp, buser, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, aruser, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, ruser, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awuser, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wuser, wvalid,
    output wready,
    output bid, bresp, buser, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, aruser, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, ruser, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_up_mem_slv.sv
// AXI4 slave with word-addressed scratch memory, independent INCR/FIXED read and write bursts.
// Define AXI_UP_MEM_BOUNDS_EN to flag beats outside the memory window as SLVERR instead of aliasing.
module axi_up_mem_slv #(
  parameter int                        AXI_ADDR_WIDTH     = 32,
  parameter int                        AXI_DATA_WIDTH     = 64,
  parameter int                        AXI_SLAVE_ID_WIDTH = 6,
  parameter int                        AXI_USER_WIDTH     = 6,
  parameter int                        MEM_DEPTH          = 512,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR          = '0
) (
  input logic             ACLK,
  input logic             ARESETn,
  axi_up_mem_slv_if.slave slv
);

  localparam int DATA_BYTES = AXI_DATA_WIDTH / 8;
  localparam int BYTE_BITS  = $clog2(DATA_BYTES);
  localparam int IDX_BITS   = $clog2(MEM_DEPTH);
  localparam logic [AXI_ADDR_WIDTH:0] MEM_BYTES = (AXI_ADDR_WIDTH+1)'(MEM_DEPTH * DATA_BYTES);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;

`ifdef AXI_UP_MEM_BOUNDS_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wState_e;
  typedef enum logic       {R_IDLE, R_DATA}         rState_e;

  function automatic logic [AXI_ADDR_WIDTH-1:0] stepAddr(
    input logic [AXI_ADDR_WIDTH-1:0] addr,
    input logic [2:0]                size,
    input logic [1:0]                burst
  );
    return (burst == BURST_FIXED) ? addr : addr + (AXI_ADDR_WIDTH'(1) << size);
  endfunction

  logic [AXI_DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  wState_e                     r_wState;
  logic [AXI_SLAVE_ID_WIDTH-1:0] r_awId;
  logic [AXI_ADDR_WIDTH-1:0]   r_awAddr;
  logic [7:0]                  r_awLen;
  logic [2:0]                  r_awSize;
  logic [1:0]                  r_awBurst;
  logic [7:0]                  r_wCnt;
  logic                        r_wErr;
  logic [AXI_SLAVE_ID_WIDTH-1:0] r_bId;
  logic [1:0]                  r_bResp;

  rState_e                     r_rState;
  logic [AXI_ADDR_WIDTH-1:0]   r_arAddr;
  logic [7:0]                  r_arLen;
  logic [2:0]                  r_arSize;
  logic [1:0]                  r_arBurst;
  logic [7:0]                  r_rCnt;
  logic [AXI_SLAVE_ID_WIDTH-1:0] r_rId;
  logic [AXI_DATA_WIDTH-1:0]   r_rData;
  logic [1:0]                  r_rResp;
  logic                        r_rLast;

  logic [AXI_ADDR_WIDTH:0]     w_wrOffExt;
  logic [IDX_BITS-1:0]         w_wrIdx;
  logic                        w_wrOut;
  logic                        w_wrHs;
  logic                        w_wrBurstBad;
  logic                        w_wrLastMis;
  logic                        w_wrBeatErr;
  logic                        w_wrEn;

  logic [AXI_ADDR_WIDTH-1:0]   w_rdAddr;
  logic [1:0]                  w_rdBurst;
  logic [AXI_ADDR_WIDTH:0]     w_rdOffExt;
  logic [IDX_BITS-1:0]         w_rdIdx;
  logic                        w_rdOut;
  logic                        w_rdBad;
  logic [AXI_DATA_WIDTH-1:0]   w_rdWord;

  // The extra top bit of the offset catches addresses below BASE_ADDR as huge offsets.
  assign w_wrOffExt   = {1'b0, r_awAddr} - {1'b0, BASE_ADDR};
  assign w_wrIdx      = w_wrOffExt[BYTE_BITS +: IDX_BITS];
  assign w_wrOut      = BOUNDS_EN && (w_wrOffExt >= MEM_BYTES);
  assign w_wrHs       = (r_wState == W_DATA) && slv.wvalid;
  assign w_wrBurstBad = r_awBurst[1];
  assign w_wrLastMis  = slv.wlast != (r_wCnt == r_awLen);
  assign w_wrBeatErr  = w_wrBurstBad | w_wrOut | w_wrLastMis;
  assign w_wrEn       = w_wrHs & ~w_wrBurstBad & ~w_wrOut;

  always_ff @(posedge ACLK) begin
    for (int b = 0; b < DATA_BYTES; b++) begin
      if (w_wrEn && slv.wstrb[b]) r_mem[w_wrIdx][8*b +: 8] <= slv.wdata[8*b +: 8];
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_wState  <= W_IDLE;
      r_awId    <= '0;
      r_awAddr  <= '0;
      r_awLen   <= '0;
      r_awSize  <= '0;
      r_awBurst <= '0;
      r_wCnt    <= '0;
      r_wErr    <= 1'b0;
      r_bId     <= '0;
      r_bResp   <= RESP_OKAY;
    end else begin
      case (r_wState)
        W_IDLE: begin
          if (slv.awvalid) begin
            r_awId    <= slv.awid;
            r_awAddr  <= slv.awaddr;
            r_awLen   <= slv.awlen;
            r_awSize  <= slv.awsize;
            r_awBurst <= slv.awburst;
            r_wCnt    <= '0;
            r_wErr    <= 1'b0;
            r_wState  <= W_DATA;
          end
        end
        W_DATA: begin
          if (slv.wvalid) begin
            r_wCnt   <= r_wCnt + 8'd1;
            r_awAddr <= stepAddr(r_awAddr, r_awSize, r_awBurst);
            r_wErr   <= r_wErr | w_wrBeatErr;
            // The beat count alone ends the burst; WLAST only feeds the error flag.
            if (r_wCnt == r_awLen) begin
              r_bId    <= r_awId;
              r_bResp  <= (r_wErr | w_wrBeatErr) ? RESP_SLVERR : RESP_OKAY;
              r_wState <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (slv.bready) r_wState <= W_IDLE;
        end
        default: r_wState <= W_IDLE;
      endcase
    end
  end

  assign slv.awready = (r_wState == W_IDLE);
  assign slv.wready  = (r_wState == W_DATA);
  assign slv.bvalid  = (r_wState == W_RESP);
  assign slv.bid     = r_bId;
  assign slv.bresp   = r_bResp;
  assign slv.buser   = '0;

  // r_arAddr always points at the next beat to fetch, so idle uses ARADDR directly.
  assign w_rdAddr   = (r_rState == R_IDLE) ? slv.araddr  : r_arAddr;
  assign w_rdBurst  = (r_rState == R_IDLE) ? slv.arburst : r_arBurst;
  assign w_rdOffExt = {1'b0, w_rdAddr} - {1'b0, BASE_ADDR};
  assign w_rdIdx    = w_rdOffExt[BYTE_BITS +: IDX_BITS];
  assign w_rdOut    = BOUNDS_EN && (w_rdOffExt >= MEM_BYTES);
  assign w_rdBad    = w_rdBurst[1] | w_rdOut;
  assign w_rdWord   = w_rdBad ? '0 : r_mem[w_rdIdx];

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_rState  <= R_IDLE;
      r_arAddr  <= '0;
      r_arLen   <= '0;
      r_arSize  <= '0;
      r_arBurst <= '0;
      r_rCnt    <= '0;
      r_rId     <= '0;
      r_rData   <= '0;
      r_rResp   <= RESP_OKAY;
      r_rLast   <= 1'b0;
    end else begin
      case (r_rState)
        R_IDLE: begin
          if (slv.arvalid) begin
            r_rId     <= slv.arid;
            r_arLen   <= slv.arlen;
            r_arSize  <= slv.arsize;
            r_arBurst <= slv.arburst;
            r_arAddr  <= stepAddr(slv.araddr, slv.arsize, slv.arburst);
            r_rCnt    <= '0;
            r_rData   <= w_rdWord;
            r_rResp   <= w_rdBad ? RESP_SLVERR : RESP_OKAY;
            r_rLast   <= (slv.arlen == 8'd0);
            r_rState  <= R_DATA;
          end
        end
        R_DATA: begin
          if (slv.rready) begin
            if (r_rLast) begin
              r_rState <= R_IDLE;
            end else begin
              r_rCnt   <= r_rCnt + 8'd1;
              r_rData  <= w_rdWord;
              r_rResp  <= w_rdBad ? RESP_SLVERR : RESP_OKAY;
              r_rLast  <= ((r_rCnt + 8'd1) == r_arLen);
              r_arAddr <= stepAddr(r_arAddr, r_arSize, r_arBurst);
            end
          end
        end
      endcase
    end
  end

  assign slv.arready = (r_rState == R_IDLE);
  assign slv.rvalid  = (r_rState == R_DATA);
  assign slv.rid     = r_rId;
  assign slv.rdata   = r_rData;
  assign slv.rresp   = r_rResp;
  assign slv.rlast   = r_rLast;
  assign slv.ruser   = '0;

  logic w_unused;
  assign w_unused = ^{slv.awlock, slv.awcache, slv.awprot, slv.awqos, slv.awregion, slv.awuser,
                      slv.arlock, slv.arcache, slv.arprot, slv.arqos, slv.arregion, slv.aruser,
                      slv.wuser, w_wrOffExt, w_rdOffExt};

endmodule

// File: tb/tb_axi_up_mem_slv.sv
// Scoreboard bench for axi_up_mem_slv: a reference memory model predicts every B and R beat,
// which are queued when stimulus is driven and popped as the DUT responds.
module tb_axi_up_mem_slv;

  localparam int          AW    = 32;
  localparam int          DW    = 64;
  localparam int          IW    = 6;
  localparam int          UW    = 6;
  localparam int          DEPTH = 512;
  localparam logic [31:0] BASE  = 32'h0;
  localparam logic [1:0]  FIXED = 2'b00;
  localparam logic [1:0]  INCR  = 2'b01;
  localparam logic [1:0]  WRAP  = 2'b10;

`ifdef AXI_UP_MEM_BOUNDS_EN
  localparam bit TB_BOUNDS = 1'b1;
`else
  localparam bit TB_BOUNDS = 1'b0;
`endif

  logic ACLK    = 1'b0;
  logic ARESETn = 1'b0;
  always #5 ACLK = ~ACLK;

  axi_up_mem_slv_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .USER_WIDTH(UW)) axiBus();

  axi_up_mem_slv #(
    .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_SLAVE_ID_WIDTH(IW),
    .AXI_USER_WIDTH(UW), .MEM_DEPTH(DEPTH), .BASE_ADDR(BASE)
  ) dut (
    .ACLK(ACLK),
    .ARESETn(ARESETn),
    .slv(axiBus)
  );

  typedef struct packed { logic [5:0] id; logic [1:0] resp; } bExp_t;
  typedef struct packed { logic [63:0] data; logic [1:0] resp; logic last; logic [5:0] id; } rExp_t;

  bExp_t       bQ[$];
  rExp_t       rQ[$];
  logic [63:0] mdl [DEPTH];
  logic [63:0] wData [16];
  logic [7:0]  wStrb [16];
  int          checks   = 0;
  int          failures = 0;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic logic mdlOut(input logic [31:0] a);
    return TB_BOUNDS && ((a < BASE) || ((a - BASE) >= 32'(DEPTH * 8)));
  endfunction

  function automatic int mdlIdx(input logic [31:0] a);
    return int'((a - BASE) >> 3) % DEPTH;
  endfunction

  function automatic logic [31:0] mdlStep(input logic [31:0] a, input logic [1:0] burst);
    return (burst == FIXED) ? a : a + 32'd8;
  endfunction

  task automatic doWrite(input logic [5:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input int lastAt, input int abortAt);
    logic [31:0] a;
    logic        err;
    logic        lastDrv;
    bExp_t       e;
    int          cyc;
    a   = addr;
    err = burst[1];
    @(negedge ACLK);
    axiBus.awid = id; axiBus.awaddr = addr; axiBus.awlen = len;
    axiBus.awsize = 3'd3; axiBus.awburst = burst; axiBus.awvalid = 1'b1;
    cyc = 0;
    while (!axiBus.awready && cyc < 50) begin @(negedge ACLK); cyc++; end
    checkOutput("aw_ready", 64'(axiBus.awready), 1);
    @(negedge ACLK);
    axiBus.awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      if (i == abortAt) begin
        axiBus.wvalid = 1'b0;
        ARESETn = 1'b0;
        repeat (2) @(negedge ACLK);
        checkOutput("rst_awready", 64'(axiBus.awready), 1);
        checkOutput("rst_wready", 64'(axiBus.wready), 0);
        checkOutput("rst_bvalid", 64'(axiBus.bvalid), 0);
        ARESETn = 1'b1;
        repeat (4) begin
          @(negedge ACLK);
          checkOutput("post_rst_bvalid", 64'(axiBus.bvalid), 0);
        end
        checkOutput("post_rst_awready", 64'(axiBus.awready), 1);
        return;
      end
      lastDrv = (lastAt >= 0) ? (i == lastAt) : (i == int'(len));
      axiBus.wdata = wData[i]; axiBus.wstrb = wStrb[i]; axiBus.wlast = lastDrv; axiBus.wvalid = 1'b1;
      cyc = 0;
      while (!axiBus.wready && cyc < 50) begin @(negedge ACLK); cyc++; end
      checkOutput("w_ready", 64'(axiBus.wready), 1);
      if (lastDrv != (i == int'(len))) err = 1'b1;
      if (mdlOut(a)) err = 1'b1;
      else if (!burst[1]) begin
        for (int b = 0; b < 8; b++)
          if (wStrb[i][b]) mdl[mdlIdx(a)][8*b +: 8] = wData[i][8*b +: 8];
      end
      a = mdlStep(a, burst);
      @(negedge ACLK);
    end
    axiBus.wvalid = 1'b0;
    axiBus.wlast  = 1'b0;
    e.id = id; e.resp = err ? 2'b10 : 2'b00;
    bQ.push_back(e);
    axiBus.bready = 1'b1;
    cyc = 0;
    while (!axiBus.bvalid && cyc < 50) begin @(negedge ACLK); cyc++; end
    checkOutput("b_latency", 64'(cyc), 0);
    checkOutput("b_valid", 64'(axiBus.bvalid), 1);
    if (bQ.size() > 0) begin
      e = bQ.pop_front();
      checkOutput("b_id", 64'(axiBus.bid), 64'(e.id));
      checkOutput("b_resp", 64'(axiBus.bresp), 64'(e.resp));
    end
    @(negedge ACLK);
    axiBus.bready = 1'b0;
    checkOutput("aw_ready_after_b", 64'(axiBus.awready), 1);
  endtask

  task automatic doRead(input logic [5:0] id, input logic [31:0] addr, input logic [7:0] len,
                        input logic [1:0] burst, input bit stall);
    logic [31:0] a;
    logic        bad;
    rExp_t       e;
    int          cyc;
    int          beats;
    bit          stalled;
    logic [63:0] heldData;
    logic        heldLast;
    a = addr;
    for (int i = 0; i <= int'(len); i++) begin
      bad    = burst[1] || mdlOut(a);
      e.data = bad ? 64'h0 : mdl[mdlIdx(a)];
      e.resp = bad ? 2'b10 : 2'b00;
      e.last = (i == int'(len));
      e.id   = id;
      rQ.push_back(e);
      a = mdlStep(a, burst);
    end
    @(negedge ACLK);
    axiBus.arid = id; axiBus.araddr = addr; axiBus.arlen = len;
    axiBus.arsize = 3'd3; axiBus.arburst = burst; axiBus.arvalid = 1'b1;
    cyc = 0;
    while (!axiBus.arready && cyc < 50) begin @(negedge ACLK); cyc++; end
    checkOutput("ar_ready", 64'(axiBus.arready), 1);
    @(negedge ACLK);
    axiBus.arvalid = 1'b0;
    checkOutput("r_latency", 64'(axiBus.rvalid), 1);
    beats    = 0;
    cyc      = 0;
    stalled  = 1'b0;
    heldData = '0;
    heldLast = 1'b0;
    while (beats <= int'(len) && cyc < 200) begin
      axiBus.rready = stall ? ((cyc % 2) == 1) : 1'b1;
      if (axiBus.rvalid) begin
        if (stalled) begin
          checkOutput("r_stall_data", axiBus.rdata, heldData);
          checkOutput("r_stall_last", 64'(axiBus.rlast), 64'(heldLast));
          stalled = 1'b0;
        end
        if (axiBus.rready) begin
          if (rQ.size() > 0) begin
            e = rQ.pop_front();
            checkOutput($sformatf("r_data[%0d]", beats), axiBus.rdata, e.data);
            checkOutput($sformatf("r_resp[%0d]", beats), 64'(axiBus.rresp), 64'(e.resp));
            checkOutput($sformatf("r_last[%0d]", beats), 64'(axiBus.rlast), 64'(e.last));
            checkOutput($sformatf("r_id[%0d]", beats), 64'(axiBus.rid), 64'(e.id));
          end
          beats++;
        end else begin
          stalled  = 1'b1;
          heldData = axiBus.rdata;
          heldLast = axiBus.rlast;
        end
      end
      @(negedge ACLK);
      cyc++;
    end
    axiBus.rready = 1'b0;
    checkOutput("r_beats", 64'(beats), 64'(int'(len) + 1));
    checkOutput("r_no_extra", 64'(axiBus.rvalid), 0);
    checkOutput("r_arready_idle", 64'(axiBus.arready), 1);
  endtask

  task automatic applyStimulus();
    for (int i = 0; i < 16; i++) wStrb[i] = 8'hFF;

    wData[0] = 64'hA5A5_0000_0000_005A;
    doWrite(6'd1, 32'h0, 8'd0, INCR, -1, -1);

    wData[0] = 64'h11; wData[1] = 64'h22; wData[2] = 64'h33; wData[3] = 64'h44;
    doWrite(6'h05, 32'h10, 8'd3, INCR, -1, -1);
    doRead(6'h09, 32'h10, 8'd3, INCR, 1'b0);

    wData[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    doWrite(6'd2, 32'h20, 8'd0, INCR, -1, -1);
    wData[0] = 64'h0; wStrb[0] = 8'h0F;
    doWrite(6'd3, 32'h20, 8'd0, INCR, -1, -1);
    wStrb[0] = 8'hFF;
    doRead(6'd4, 32'h20, 8'd0, INCR, 1'b0);

    for (int i = 0; i < 8; i++) wData[i] = 64'h0101_0101_0101_0101 * (i + 3);
    doWrite(6'd5, 32'h80, 8'd7, INCR, -1, -1);
    doRead(6'd6, 32'h80, 8'd7, INCR, 1'b1);

    wData[0] = 64'hAAAA; wData[1] = 64'hBBBB; wData[2] = 64'hCCCC;
    doWrite(6'd7, 32'h40, 8'd2, FIXED, -1, -1);
    doRead(6'd8, 32'h40, 8'd0, INCR, 1'b0);

    doWrite(6'd9, 32'h200, 8'd2, INCR, 1, -1);

    doRead(6'd10, 32'h10, 8'd1, WRAP, 1'b0);
    doWrite(6'd11, 32'h300, 8'd1, WRAP, -1, -1);
    doRead(6'd12, 32'h300, 8'd1, INCR, 1'b1);

    wData[0] = 64'hDEAD_BEEF_0BAD_F00D;
    doWrite(6'd13, 32'hFF8, 8'd0, INCR, -1, -1);
    doRead(6'd14, 32'hFF8, 8'd1, INCR, 1'b0);

    wData[0] = 64'h1000_0001; wData[1] = 64'h1000_0002; wData[2] = 64'h1000_0003; wData[3] = 64'h1000_0004;
    doWrite(6'd15, 32'h100, 8'd3, INCR, -1, 2);
    doRead(6'd16, 32'h100, 8'd1, INCR, 1'b0);
    wData[0] = 64'h5555_0001; wData[1] = 64'h5555_0002;
    doWrite(6'd17, 32'h180, 8'd1, INCR, -1, -1);
    doRead(6'd18, 32'h180, 8'd1, INCR, 1'b1);
  endtask

  initial begin
    axiBus.awid = '0; axiBus.awaddr = '0; axiBus.awlen = '0; axiBus.awsize = '0; axiBus.awburst = '0;
    axiBus.awlock = 1'b0; axiBus.awcache = '0; axiBus.awprot = '0; axiBus.awqos = '0;
    axiBus.awregion = '0; axiBus.awuser = '0; axiBus.awvalid = 1'b0;
    axiBus.wdata = '0; axiBus.wstrb = '0; axiBus.wlast = 1'b0; axiBus.wuser = '0; axiBus.wvalid = 1'b0;
    axiBus.bready = 1'b0;
    axiBus.arid = '0; axiBus.araddr = '0; axiBus.arlen = '0; axiBus.arsize = '0; axiBus.arburst = '0;
    axiBus.arlock = 1'b0; axiBus.arcache = '0; axiBus.arprot = '0; axiBus.arqos = '0;
    axiBus.arregion = '0; axiBus.aruser = '0; axiBus.arvalid = 1'b0;
    axiBus.rready = 1'b0;

    ARESETn = 1'b0;
    repeat (3) @(negedge ACLK);
    checkOutput("rst_awready", 64'(axiBus.awready), 1);
    checkOutput("rst_arready", 64'(axiBus.arready), 1);
    checkOutput("rst_wready", 64'(axiBus.wready), 0);
    checkOutput("rst_bvalid", 64'(axiBus.bvalid), 0);
    checkOutput("rst_rvalid", 64'(axiBus.rvalid), 0);
    checkOutput("rst_bresp", 64'(axiBus.bresp), 0);
    checkOutput("rst_rresp", 64'(axiBus.rresp), 0);
    checkOutput("rst_rdata", axiBus.rdata, 0);
    checkOutput("rst_rlast", 64'(axiBus.rlast), 0);
    checkOutput("rst_bid", 64'(axiBus.bid), 0);
    checkOutput("rst_rid", 64'(axiBus.rid), 0);
    checkOutput("rst_buser", 64'(axiBus.buser), 0);
    checkOutput("rst_ruser", 64'(axiBus.ruser), 0);
    ARESETn = 1'b1;
    @(negedge ACLK);

    applyStimulus();

    checkOutput("r_queue_drained", 64'(rQ.size()), 0);
    checkOutput("b_queue_drained", 64'(bQ.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
